// File: rtl/pulse_sequencer.sv
// pulse_sequencer: two-pulse echo sequencer (P1, gap, P2) with scope sync and
// receiver-protect block gate. Timing parameters are shadowed at each period
// boundary so live register updates only ever affect the next whole period.
//
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   run           sequencer enable, sampled at period boundaries
//   per           period in cycles (floored to MIN_PERIOD)
//   p1wid, del,
//   p2wid         P1 width, P1-end to P2-start gap, P2 width (cycles)
//   pu, bl        P1 enable, block-gate enable
//   p_bl          extra block hold after P2 end (cycles)
//   p_bl_off      block-open window length (cycles)
//   sync, p1, p2, blk, busy   registered sequence outputs
//   per_cnt       completed-period counter (wraps)
module pulse_sequencer #(
  parameter logic [31:0] MIN_PERIOD = 32'd4,
  parameter logic [31:0] SYNC_LEN   = 32'd40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] per,
  input  logic [31:0] p1wid,
  input  logic [31:0] del,
  input  logic [31:0] p2wid,
  input  logic        pu,
  input  logic        bl,
  input  logic [7:0]  p_bl,
  input  logic [15:0] p_bl_off,
  output logic        sync,
  output logic        p1,
  output logic        p2,
  output logic        blk,
  output logic        busy,
  output logic [15:0] per_cnt
);

  localparam int unsigned CW = 32;
  localparam int unsigned EW = 34;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [CW-1:0]   per_s;
  logic            pu_s, bl_s;
  logic [EW-1:0]   e1, e2, e3, e4, e5;
  logic [EW-1:0]   e1_c, e2_c, e3_c, e4_c, e5_c;
  logic [EW-1:0]   k_c;
  logic [CW-1:0]   per_floor_c;
  logic            load_c, per_end_c;
  logic            sync_nxt, p1_nxt, p2_nxt, blk_nxt, busy_nxt;

  // Edge offsets from live inputs; 34 bits so the sums can never wrap.
  always_comb begin
    e1_c        = EW'(p1wid);
    e2_c        = e1_c + EW'(del);
    e3_c        = e2_c + EW'(p2wid);
    e4_c        = e3_c + EW'(p_bl);
    e5_c        = e4_c + EW'(p_bl_off);
    per_floor_c = (per < MIN_PERIOD) ? MIN_PERIOD : per;
  end

  // Next-state, load decision and next output values.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    load_c    = 1'b0;
    per_end_c = 1'b0;
    sync_nxt  = 1'b0;
    p1_nxt    = 1'b0;
    p2_nxt    = 1'b0;
    blk_nxt   = 1'b0;
    busy_nxt  = 1'b0;
    k_c       = EW'(cnt);
    case (state)
      IDLE: begin
        if (run) begin
          load_c    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = RUN;
        end
      end
      RUN: begin
        cnt_nxt  = cnt + 32'd1;
        busy_nxt = 1'b1;
        sync_nxt = (cnt < SYNC_LEN);
        p1_nxt   = pu_s & (k_c < e1);
        p2_nxt   = (k_c >= e2) & (k_c < e3);
        blk_nxt  = bl_s & ~((k_c >= e4) & (k_c < e5));
        // Last cycle of the period: reload seamlessly or drop back to IDLE.
        if (cnt == per_s - 32'd1) begin
          per_end_c = 1'b1;
          cnt_nxt   = '0;
          if (run) begin
            load_c = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters, shadows and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      per_cnt <= '0;
      per_s   <= MIN_PERIOD;
      pu_s    <= 1'b0;
      bl_s    <= 1'b0;
      e1      <= '0;
      e2      <= '0;
      e3      <= '0;
      e4      <= '0;
      e5      <= '0;
      sync    <= 1'b0;
      p1      <= 1'b0;
      p2      <= 1'b0;
      blk     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (per_end_c) begin
        per_cnt <= per_cnt + 16'd1;
      end
      if (load_c) begin
        per_s <= per_floor_c;
        pu_s  <= pu;
        bl_s  <= bl;
        e1    <= e1_c;
        e2    <= e2_c;
        e3    <= e3_c;
        e4    <= e4_c;
        e5    <= e5_c;
      end
      sync <= sync_nxt;
      p1   <= p1_nxt;
      p2   <= p2_nxt;
      blk  <= blk_nxt;
      busy <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Testbench for pulse_sequencer: directed scenarios then randomized traffic,
// every cycle compared against a period-level reference model.
module tb_pulse_sequencer;

  localparam logic [31:0] TB_SYNC = 32'd4;
  localparam logic [31:0] TB_MINP = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [31:0] per = 32'd20, p1wid = 32'd3, del = 32'd4, p2wid = 32'd2;
  logic        pu = 1'b1, bl = 1'b1;
  logic [7:0]  p_bl = 8'd2;
  logic [15:0] p_bl_off = 16'd5;
  logic        sync, p1, p2, blk, busy;
  logic [15:0] per_cnt;

  int errors = 0;
  int checks = 0;

  pulse_sequencer #(.MIN_PERIOD(TB_MINP), .SYNC_LEN(TB_SYNC)) dut (
    .clk(clk), .rst(rst), .run(run), .per(per), .p1wid(p1wid), .del(del),
    .p2wid(p2wid), .pu(pu), .bl(bl), .p_bl(p_bl), .p_bl_off(p_bl_off),
    .sync(sync), .p1(p1), .p2(p2), .blk(blk), .busy(busy), .per_cnt(per_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: tracks which period is on display and its offset k.
  bit              m_act = 0, m_pend = 0;
  longint unsigned m_k = 0;
  longint unsigned c_per = 4, n_per = 4;
  bit              c_pu = 0, c_bl = 0, n_pu = 0, n_bl = 0;
  longint unsigned c_w1, c_g, c_w2, c_h, c_o;
  longint unsigned n_w1, n_g, n_w2, n_h, n_o;
  logic [15:0]     m_pcnt = 16'd0;

  task automatic model_edge();
    if (rst) begin
      m_act = 0; m_pend = 0; m_pcnt = 16'd0;
    end else begin
      if (m_pend) begin
        m_act = 1; m_k = 0; m_pend = 0;
        c_per = n_per; c_pu = n_pu; c_bl = n_bl;
        c_w1 = n_w1; c_g = n_g; c_w2 = n_w2; c_h = n_h; c_o = n_o;
      end else if (m_act && (m_k + 1 < c_per)) begin
        m_k = m_k + 1;
      end else begin
        m_act = 0;
      end
      if (m_act && m_k == c_per - 1) m_pcnt = m_pcnt + 16'd1;
      if ((!m_act || m_k == c_per - 1) && run) begin
        m_pend = 1;
        n_per = (per < TB_MINP) ? longint'(TB_MINP) : longint'(per);
        n_pu = pu; n_bl = bl;
        n_w1 = p1wid; n_g = del; n_w2 = p2wid; n_h = p_bl; n_o = p_bl_off;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
    end
  endtask

  // One clock: advance model at the edge, compare all outputs 1 time unit later.
  task automatic tick();
    longint unsigned s1, s2, s3, s4, s5;
    bit es, e1b, e2b, ebk, ebu;
    @(posedge clk);
    model_edge();
    #1;
    es = 0; e1b = 0; e2b = 0; ebk = 0; ebu = 0;
    if (m_act) begin
      s1 = c_w1; s2 = s1 + c_g; s3 = s2 + c_w2; s4 = s3 + c_h; s5 = s4 + c_o;
      ebu = 1;
      es  = (m_k < longint'(TB_SYNC));
      e1b = c_pu && (m_k < s1);
      e2b = (m_k >= s2) && (m_k < s3);
      ebk = c_bl && !((m_k >= s4) && (m_k < s5));
    end
    chk("sync", 32'(sync), 32'(es));
    chk("p1", 32'(p1), 32'(e1b));
    chk("p2", 32'(p2), 32'(e2b));
    chk("blk", 32'(blk), 32'(ebk));
    chk("busy", 32'(busy), 32'(ebu));
    chk("per_cnt", 32'(per_cnt), 32'(m_pcnt));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1; run = 1'b0;
    ticks(3);
    rst = 1'b0;
    ticks(2);

    // Nominal sequence: three full periods
    run = 1'b1;
    ticks(61);
    chk("per_cnt_after_3", 32'(per_cnt), 32'd3);

    // P1 and block suppressed, timing unchanged
    pu = 1'b0; bl = 1'b0;
    ticks(45);

    // Mid-period width change only affects the next period
    pu = 1'b1; bl = 1'b1;
    ticks(22);
    p1wid = 32'd6;
    ticks(45);

    // Period below floor: p2 window never reached
    p1wid = 32'd3; per = 32'd2;
    ticks(30);

    // run drops mid-period, then restart
    per = 32'd20;
    ticks(25);
    run = 1'b0;
    ticks(30);
    chk("busy_idle", 32'(busy), 32'd0);
    run = 1'b1;
    ticks(7);

    // Reset mid-period
    rst = 1'b1;
    ticks(1);
    chk("rst_pcnt", 32'(per_cnt), 32'd0);
    rst = 1'b0;
    ticks(10);

    // Huge widths: no wrap in edge arithmetic
    p1wid = 32'hFFFF_FFF0; del = 32'h20; per = 32'd100;
    ticks(230);
    chk("p1_huge", 32'(p1), 32'd1);
    p1wid = 32'd3; del = 32'd4;

    // Randomized traffic, run toggling including on period boundaries
    for (int seg = 0; seg < 40; seg++) begin
      per      = 32'($urandom_range(0, 24));
      p1wid    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 10));
      del      = 32'($urandom_range(0, 10));
      p2wid    = 32'($urandom_range(0, 6));
      pu       = 1'($urandom_range(0, 1));
      bl       = 1'($urandom_range(0, 1));
      p_bl     = 8'($urandom_range(0, 5));
      p_bl_off = 16'($urandom_range(0, 8));
      for (int c = 0; c < 30; c++) begin
        if ($urandom_range(0, 9) == 0) run = ~run;
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
      rst = 1'b0;
    end

    run = 1'b0;
    ticks(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pulse_sequencer.md
Name: pulse_sequencer

Overview:
- Generates the two-pulse echo sequence (P1, delay, P2), the scope sync and the receiver-protect block gate.
- Timing comes from the UART-loaded pulse parameter registers.
- Sits between the serial control block and the RF switch/trigger pins, on the 201 MHz clock; 1 cycle ≈ 4.975 ns.
- Parameters are shadowed at each period boundary, so serial updates never produce a truncated or glitched pulse.

Parameters:
MIN_PERIOD, 32'd4, floor applied to the period input; smaller values are replaced by this.
SYNC_LEN, 32'd40, sync pulse length in cycles (≈200 ns).

Ports:
clk  in  1  system clock (201 MHz)
rst  in  1  synchronous active-high reset; only clock and reset into the block
run  in  1  sequencer enable
per  in  32  period, cycles
p1wid  in  32  P1 width, cycles
del  in  32  P1-end to P2-start gap, cycles
p2wid  in  32  P2 width, cycles
pu  in  1  P1 enable; 0 suppresses P1, timing unchanged
bl  in  1  block-gate enable
p_bl  in  8  extra block hold after P2 end, cycles
p_bl_off  in  16  block-open window length, cycles
sync  out  1  scope/digitizer trigger
p1  out  1  first pulse
p2  out  1  second pulse
blk  out  1  receiver block (1 = blocked)
busy  out  1  high while in RUN
per_cnt  out  16  completed-period counter, wraps at 16'hFFFF→0

Behaviour:
- Reset: state IDLE, internal cnt=0, per_cnt=0, all outputs 0 on the cycle after the rst edge. Reset mid-period takes effect immediately; no completion of the current period.
- States: IDLE, RUN.
- Load event: IDLE with run=1, or RUN with cnt==per_s-1 and run=1.
- On a load event, at the same edge:
  - shadows load from live inputs:
    - per_s = max(per, MIN_PERIOD)
    - pu_s, bl_s
  - edges load, all 34-bit unsigned, no wrap:
    - e1 = p1wid
    - e2 = e1 + del
    - e3 = e2 + p2wid
    - e4 = e3 + p_bl
    - e5 = e4 + p_bl_off
  - cnt <= 0; state <= RUN.
- RUN:
  - cnt increments each cycle.
  - At cnt==per_s-1:
    - per_cnt increments.
    - If run=1: load event.
    - If run=0: state <= IDLE, cnt <= 0.
- Outputs are registered from cnt, one cycle latency. Relative to S (the first cycle sync=1, one cycle after the load edge), in period offset k = 0..per_s-1:
  - sync = (k < SYNC_LEN)
  - p1 = pu_s & (k < e1)
  - p2 = (k >= e2) & (k < e3)
  - blk = bl_s & ~((k >= e4) & (k < e5))
  - busy = 1
- Any window extending past per_s-1 is truncated at the period end. Nothing carries into the next period.
- p1wid=0 → no P1. p2wid=0 → no P2. p_bl_off=0 → blk never opens.
- Back-to-back periods: the next S is exactly per_s cycles after the previous S, with no gap cycle.
- IDLE outputs: sync=p1=p2=blk=busy=0.
- Input changes mid-period affect only the next period. This includes pu, bl and per itself.
- run deassert mid-period: the current period completes unmodified. Outputs are 0 from the cycle after the last period cycle.
- run re-asserted on the final cycle of a period: treated as a load event, continuous.

Test Plan:
1. per=20, p1wid=3, del=4, p2wid=2, pu=1, bl=1, p_bl=2, p_bl_off=5, SYNC_LEN=4, run=1 → p1 at k=0..2, p2 at k=7..8, blk=0 at k=11..15 else 1, sync k=0..3; next S at +20; per_cnt increments each period.
2. Same as 1 with pu=0, bl=0 → p1 and blk stay 0; p2 still at k=7..8; period unchanged.
3. Change p1wid 3→6 at k=1 → current period P1 still ends at k=2; next period P1 at k=0..5 and P2 at k=10..11.
4. per=2 → effective period 4; p2 window (k=7..8) fully truncated, p2 never high; sync k=0..3 every 4 cycles.
5. run drops at k=5 → period completes through k=19, then all outputs 0, busy=0. Separately, rst at k=5 → all outputs 0 and per_cnt=0 next cycle.
6. p1wid=32'hFFFFFFF0, del=32'h20, per=100 → no 32-bit wrap; p1 high whole period, p2 never high.
